pipe_stall_ctrl: RTL
====================

// Module: pipe_stall_ctrl
// PURPOSE
// - Central stall scheduler for the 5-stage MIPS pipeline (PC/IF/ID/EX/MEM/WB).
// - Merges stall requests into the shared stall bus:
//   - ID load-use stall.
//   - EX multi-cycle divider, which this block sequences via a start/ready handshake with timeout.
//   - MEM data-SRAM wait.
// - Keeps saturating stall/divide performance counters for debug.
// PARAMETERS
// - STALL_W  6   stall bus width; bit0=PC, 1=IF, 2=ID, 3=EX, 4=MEM, 5=WB.
// - DIV_TMO  40  max cycles from div_start to div_ready before abort.
// - CNT_W    32  perf counter width.
// PORTS
// - clk            in   1        clock
// - rst            in   1        reset, synchronous, active-high
// - stallreq_id    in   1        ID load-use hazard (EX is a load; EX dest matches rs/rt)
// - ex_div_req     in   1        EX holds div/divu, level while instr sits in EX
// - div_ready      in   1        divider result valid, 1-cycle pulse
// - mem_wait       in   1        data SRAM not ready; MEM must hold
// - stall          out  STALL_W  stall bus; 1=Stop
// - div_start      out  1        1-cycle start pulse to divider
// - div_annul      out  1        1-cycle abort pulse to divider
// - div_done       out  1        EX latches quotient/remainder this cycle
// - div_err        out  1        sticky: a divide timed out; cleared only by rst
// - stall_cycles   out  CNT_W    saturating count of cycles with stall!=0
// - div_count      out  CNT_W    saturating count of completed divides
// BEHAVIOUR
// - Reset values:
//   - state=IDLE, tmo counter=0, div_err=0, counters=0.
//   - All pulse outputs 0; stall=0 while rst high.
// - stall is combinational from inputs and state; zero-cycle latency (ID request is same-cycle).
// - Priority, deepest wins; pattern stalls stage k and all upstream, bubble into k+1:
//   - mem_wait -> 6'b011111.
//   - div_hold -> 6'b001111.
//   - stallreq_id -> 6'b000111.
//   - otherwise 6'b000000.
// - div_hold = (IDLE & ex_div_req) | RUN.
// - FSM states IDLE, RUN, DONE:
//   - IDLE: if ex_div_req & !mem_wait, pulse div_start, load tmo=0, go RUN.
//     - If ex_div_req & mem_wait: stay IDLE, no start (EX already frozen).
//   - RUN: tmo increments each cycle.
//     - div_ready: div_done=1, div_count+1 (saturating), go DONE.
//     - else tmo==DIV_TMO-1: div_annul=1, div_err<=1, div_done=1 (EX takes garbage, pipeline proceeds), go DONE.
//     - div_ready and timeout in the same cycle: ready wins; no annul, no err.
//   - DONE: div_hold=0, so EX may advance.
//     - stall[3]==0 (no mem_wait): go IDLE.
//     - else hold DONE; ex_div_req is ignored in DONE, so no restart of the same instr.
// - Back-to-back divides: the second div enters EX when FSM is IDLE; it starts the next cycle after DONE.
// - div_ready outside RUN is ignored.
// - Counters: saturate at all-ones, no wrap.
//   - stall_cycles increments when stall!=0 and rst=0.
// - Reset mid-divide: FSM -> IDLE next edge, no annul pulse; the divider shares rst.
// STRUCTURE
// - `Stop/`NoStop, StallBus width, the three stall patterns and the FSM state encodings go in lib/defines.vh.
// - One sub-module: sat_counter (parameter W; inputs clk, rst, inc; output cnt), instantiated twice.
// - FSM and stall mux live in pipe_stall_ctrl.
// TESTING
// - Load-use: stallreq_id=1 for 1 cycle -> stall=6'b000111 that cycle only; stall_cycles=1.
// - Divide, div_ready 33 cycles after start:
//   - div_start pulses once; stall=6'b001111 for 34 cycles.
//   - div_done with ready; stall=0 in DONE; div_count=1.
// - mem_wait=1 for 3 cycles while in RUN -> stall=6'b011111 those cycles.
//   - After ready, FSM holds DONE until mem_wait=0; no second div_start.
// - No div_ready, DIV_TMO=40 -> div_annul and div_done at cycle 40 after start; div_err=1 until rst.
// - rst asserted in RUN cycle 10 -> next cycle state IDLE, stall=0, counters=0, no div_annul.
// - Two back-to-back divs, each ready after 5 cycles -> two div_start pulses separated by 7 cycles; div_count=2.

Source files
------------

// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared types and constants for the pipeline stall scheduler: stall-bus patterns,
// divider FSM state encoding and the priority helper that builds the stall bus.
package pipe_stall_ctrl_pkg;

    localparam int STALL_BUS_W  = 6;
    localparam int STALL_EX_BIT = 3;

    typedef logic [STALL_BUS_W-1:0] stall_bus_t;

    localparam logic NO_STOP = 1'b0;

    // Each pattern freezes stage k and everything upstream; stage k+1 takes a bubble.
    localparam stall_bus_t STALL_NONE = 6'b000000;
    localparam stall_bus_t STALL_ID   = 6'b000111;
    localparam stall_bus_t STALL_DIV  = 6'b001111;
    localparam stall_bus_t STALL_MEM  = 6'b011111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } div_state_t;

    // Deepest requester wins.
    function automatic stall_bus_t stall_pattern(input logic mem_req,
                                                 input logic div_req,
                                                 input logic id_req);
        stall_bus_t pat;
        if (mem_req)      pat = STALL_MEM;
        else if (div_req) pat = STALL_DIV;
        else if (id_req)  pat = STALL_ID;
        else              pat = STALL_NONE;
        return pat;
    endfunction

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// Pipeline-side bundle of the stall scheduler: hazard/divider/memory requests in,
// stall bus, divider handshake pulses and debug counters out.
interface pipe_stall_ctrl_if
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int STALL_W = STALL_BUS_W,
    parameter int CNT_W   = 32
);
    logic               stallreq_id;
    logic               ex_div_req;
    logic               div_ready;
    logic               mem_wait;
    logic [STALL_W-1:0] stall;
    logic               div_start;
    logic               div_annul;
    logic               div_done;
    logic               div_err;
    logic [CNT_W-1:0]   stall_cycles;
    logic [CNT_W-1:0]   div_count;

    modport master (
        output stallreq_id, ex_div_req, div_ready, mem_wait,
        input  stall, div_start, div_annul, div_done, div_err,
               stall_cycles, div_count
    );

    modport slave (
        input  stallreq_id, ex_div_req, div_ready, mem_wait,
        output stall, div_start, div_annul, div_done, div_err,
               stall_cycles, div_count
    );
endinterface

// File: rtl/pipe_stall_ctrl_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);
    logic [W-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (inc && (cnt_reg != '1)) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign cnt = cnt_reg;
endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central stall scheduler: merges load-use, divider and data-SRAM stalls into the
// shared stall bus and sequences the multi-cycle divider with a timeout.
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int STALL_W = 6,
    parameter int DIV_TMO = 40,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    pipe_stall_ctrl_if.slave bus
);
    localparam int TMO_W = $clog2(DIV_TMO + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(DIV_TMO - 1);

    div_state_t       state_reg;
    logic [TMO_W-1:0] tmo_reg;
    logic             div_err_reg;

    logic       div_hold;
    logic       start_now;
    logic       ready_hit;
    logic       tmo_hit;
    stall_bus_t stall_now;

    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] div_cnt;

    // Everything here is same-cycle so an ID hazard freezes the front end immediately.
    always_comb begin
        div_hold  = 1'b0;
        start_now = 1'b0;
        ready_hit = 1'b0;
        tmo_hit   = 1'b0;
        stall_now = STALL_NONE;
        if (!rst) begin
            div_hold  = ((state_reg == ST_IDLE) && bus.ex_div_req) || (state_reg == ST_RUN);
            start_now = (state_reg == ST_IDLE) && bus.ex_div_req && !bus.mem_wait;
            ready_hit = (state_reg == ST_RUN) && bus.div_ready;
            tmo_hit   = (state_reg == ST_RUN) && !bus.div_ready && (tmo_reg == TMO_LAST);
            stall_now = stall_pattern(bus.mem_wait, div_hold, bus.stallreq_id);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            tmo_reg     <= '0;
            div_err_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start_now) begin
                        tmo_reg   <= '0;
                        state_reg <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    tmo_reg <= tmo_reg + 1'b1;
                    if (ready_hit) begin
                        state_reg <= ST_DONE;
                    end else if (tmo_hit) begin
                        div_err_reg <= 1'b1;
                        state_reg   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // The div stays in EX while MEM holds; waiting here stops a restart of it.
                    if (stall_now[STALL_EX_BIT] == NO_STOP) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < STALL_W; gi++) begin : g_stall
            if (gi < STALL_BUS_W) begin : g_bit
                assign bus.stall[gi] = stall_now[gi];
            end else begin : g_pad
                assign bus.stall[gi] = NO_STOP;
            end
        end
    endgenerate

    assign bus.div_start = start_now;
    assign bus.div_annul = tmo_hit;
    assign bus.div_done  = ready_hit | tmo_hit;
    assign bus.div_err   = div_err_reg;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (stall_now != STALL_NONE),
        .cnt (stall_cnt)
    );

    // Only divides that actually returned a result count; timeouts do not.
    sat_counter #(.W(CNT_W)) u_div_cnt (
        .clk (clk),
        .rst (rst),
        .inc (ready_hit),
        .cnt (div_cnt)
    );

    assign bus.stall_cycles = stall_cnt;
    assign bus.div_count    = div_cnt;
endmodule
